cpu_mem_loader: RTL

//  Upstream boot/readback engine for the cpu core. Accepts a 64-bit word stream, writes DMEM_WORDS words

---
 rtl/cpu_mem_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - boot loader and post-halt dmem readback engine for the cpu core
//
// Loads DMEM_WORDS words from the input stream into data memory (ext_2 port), then
// IMEM_WORDS words into instruction memory (ext port), then runs the cpu via enable.
// When the cpu halts, enable drops and the first DUMP_WORDS dmem words are read back
// and streamed out on the m_* handshake; done then stays high until the next start.
//
// Ports:
//   clk, arst_n                  clock, asynchronous active-low reset
//   start                        begin a (re)load; honoured only in IDLE or DONE
//   s_valid/s_ready/s_data       64-bit load stream, dmem words first, then imem words
//   halt                         cpu reached STOP; honoured only in RUN
//   addr_ext/wen_ext/ren_ext/wdata_ext               imem port (write-only)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2       dmem port (writes, then dump reads)
//   rdata_ext_2                  dmem read data, valid the cycle after ren_ext_2
//   enable                       cpu run enable
//   m_valid/m_ready/m_data       dump stream
//   done                         dump complete
module cpu_mem_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int DUMP_WORDS = 47
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        halt,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [63:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        enable,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        done
);

    // One load index serves both phases, so it is sized for the larger memory.
    localparam int MAX_WORDS = (DMEM_WORDS > IMEM_WORDS) ? DMEM_WORDS : IMEM_WORDS;
    localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int J_W       = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

    localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DMEM_WORDS - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(IMEM_WORDS - 1);
    localparam logic [J_W-1:0]   J_LAST = J_W'(DUMP_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_D,
        LOAD_I,
        GAP,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [J_W-1:0]     j_q;
    logic [63:0]        addr_ext_q;
    logic               wen_ext_q;
    logic [63:0]        wdata_ext_q;
    logic [63:0]        addr_ext_2_q;
    logic               wen_ext_2_q;
    logic               ren_ext_2_q;
    logic [63:0]        wdata_ext_2_q;
    logic               enable_q;
    logic               m_valid_q;
    logic [63:0]        m_data_q;
    logic               done_q;

    // Word index to 64-bit byte address; upper bits are always zero.
    function automatic logic [63:0] byte_addr(input logic [IDX_W-1:0] i);
        return {{(61 - IDX_W){1'b0}}, i, 3'b000};
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            j_q           <= '0;
            addr_ext_q    <= '0;
            wen_ext_q     <= 1'b0;
            wdata_ext_q   <= '0;
            addr_ext_2_q  <= '0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            wdata_ext_2_q <= '0;
            enable_q      <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            wen_ext_q   <= 1'b0;
            wen_ext_2_q <= 1'b0;
            ren_ext_2_q <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LOAD_D;
                        idx_q   <= '0;
                        j_q     <= '0;
                        done_q  <= 1'b0;
                    end
                end

                LOAD_D: begin
                    if (s_valid) begin
                        wen_ext_2_q   <= 1'b1;
                        addr_ext_2_q  <= byte_addr(idx_q);
                        wdata_ext_2_q <= s_data;
                        if (idx_q == D_LAST) begin
                            state_q <= LOAD_I;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                LOAD_I: begin
                    if (s_valid) begin
                        wen_ext_q   <= 1'b1;
                        addr_ext_q  <= byte_addr(idx_q);
                        wdata_ext_q <= s_data;
                        if (idx_q == I_LAST) begin
                            state_q <= GAP;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                // The final imem write pulse lands here, before the cpu is enabled.
                GAP: begin
                    state_q  <= RUN;
                    enable_q <= 1'b1;
                end

                RUN: begin
                    if (halt) begin
                        state_q      <= DUMP_RD;
                        enable_q     <= 1'b0;
                        ren_ext_2_q  <= 1'b1;
                        addr_ext_2_q <= byte_addr(IDX_W'(j_q));
                    end
                end

                DUMP_RD: begin
                    state_q <= DUMP_WAIT;
                end

                DUMP_WAIT: begin
                    m_data_q  <= rdata_ext_2;
                    m_valid_q <= 1'b1;
                    state_q   <= DUMP_OUT;
                end

                DUMP_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (j_q == J_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            j_q          <= j_q + 1'b1;
                            state_q      <= DUMP_RD;
                            ren_ext_2_q  <= 1'b1;
                            addr_ext_2_q <= byte_addr(IDX_W'(j_q + 1'b1));
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is a pure state decode so upstream sees no combinational path from s_valid.
    assign s_ready     = (state_q == LOAD_D) || (state_q == LOAD_I);
    assign ren_ext     = 1'b0;
    assign addr_ext    = addr_ext_q;
    assign wen_ext     = wen_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign enable      = enable_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign done        = done_q;

endmodule
